// File: rtl/led_flash_out_if.sv
// Event/LED handshake bundle between control logic and the LED flasher.
interface led_flash_out_if #(
    parameter int PEND_W = 4
);
    logic              evt_in;
    logic              clear;
    logic              led_out;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              overflow;

    modport master (
        output evt_in,
        output clear,
        input  led_out,
        input  busy,
        input  pending,
        input  overflow
    );

    modport slave (
        input  evt_in,
        input  clear,
        output led_out,
        output busy,
        output pending,
        output overflow
    );
endinterface

// File: rtl/led_flash_out.sv
// LED flasher: turns single-cycle event strobes into visible flashes paced by a
// free-running tick. Events arriving mid-flash are queued in a saturating counter.
module led_flash_out #(
    parameter logic [19:0] TICK_MAX  = 20'd1000000,
    parameter logic [7:0]  ON_TICKS  = 8'd20,
    parameter logic [7:0]  GAP_TICKS = 8'd10,
    parameter int          PEND_W    = 4
) (
    input  logic             clock,
    input  logic             reset,
    led_flash_out_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] PEND_ZERO = {PEND_W{1'b0}};
    localparam logic [PEND_W-1:0] PEND_ONE  = {{(PEND_W-1){1'b0}}, 1'b1};

    state_t            state_r;
    logic [19:0]       tick_cnt_r;
    logic [7:0]        phase_cnt_r;
    logic              led_r;
    logic              busy_r;
    logic [PEND_W-1:0] pending_r;
    logic              overflow_r;

    logic tick_s;
    logic on_done_s;
    logic gap_done_s;
    logic pend_inc_s;
    logic pend_dec_s;

    // A phase ends on the edge that closes the cycle carrying its Nth tick,
    // so the count of ticks already seen must be N-1 when that tick arrives.
    always_comb begin
        tick_s     = (tick_cnt_r == TICK_MAX);
        on_done_s  = tick_s && (phase_cnt_r == (ON_TICKS - 8'd1));
        gap_done_s = tick_s && (phase_cnt_r == (GAP_TICKS - 8'd1));
        if (state_r != ST_IDLE) begin
            pend_inc_s = bus.evt_in;
        end else begin
            pend_inc_s = 1'b0;
        end
        if ((state_r == ST_GAP) && gap_done_s && (pending_r != PEND_ZERO)) begin
            pend_dec_s = 1'b1;
        end else begin
            pend_dec_s = 1'b0;
        end
    end

    // Free-running tick counter; never paused, restarted or cleared by clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_cnt_r <= 20'd0;
        end else if (tick_s) begin
            tick_cnt_r <= 20'd0;
        end else begin
            tick_cnt_r <= tick_cnt_r + 20'd1;
        end
    end

    // Flash FSM with phase counter, pending queue and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            phase_cnt_r <= 8'd0;
            led_r       <= 1'b0;
            busy_r      <= 1'b0;
            pending_r   <= PEND_ZERO;
            overflow_r  <= 1'b0;
        end else if (bus.clear) begin
            state_r     <= ST_IDLE;
            phase_cnt_r <= 8'd0;
            led_r       <= 1'b0;
            busy_r      <= 1'b0;
            pending_r   <= PEND_ZERO;
            overflow_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    phase_cnt_r <= 8'd0;
                    if (bus.evt_in) begin
                        state_r <= ST_ON;
                        led_r   <= 1'b1;
                        busy_r  <= 1'b1;
                    end else begin
                        led_r   <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                end
                ST_ON: begin
                    if (on_done_s) begin
                        state_r     <= ST_GAP;
                        led_r       <= 1'b0;
                        phase_cnt_r <= 8'd0;
                    end else if (tick_s) begin
                        phase_cnt_r <= phase_cnt_r + 8'd1;
                    end else begin
                        phase_cnt_r <= phase_cnt_r;
                    end
                end
                ST_GAP: begin
                    if (gap_done_s) begin
                        phase_cnt_r <= 8'd0;
                        if (pending_r != PEND_ZERO) begin
                            state_r <= ST_ON;
                            led_r   <= 1'b1;
                        end else begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else if (tick_s) begin
                        phase_cnt_r <= phase_cnt_r + 8'd1;
                    end else begin
                        phase_cnt_r <= phase_cnt_r;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    phase_cnt_r <= 8'd0;
                    led_r       <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase

            // A queued event and a dequeue in the same cycle cancel out.
            if (pend_inc_s && !pend_dec_s) begin
                if (pending_r == PEND_MAX) begin
                    overflow_r <= 1'b1;
                end else begin
                    pending_r <= pending_r + PEND_ONE;
                end
            end else if (pend_dec_s && !pend_inc_s) begin
                pending_r <= pending_r - PEND_ONE;
            end else begin
                pending_r <= pending_r;
            end
        end
    end

    assign bus.led_out  = led_r;
    assign bus.busy     = busy_r;
    assign bus.pending  = pending_r;
    assign bus.overflow = overflow_r;

endmodule

// File: tb/tb_led_flash_out.sv
// Bench for led_flash_out: per-cycle comparison against a timeline model plus
// hand-computed checkpoints (P=10, ON_TICKS=2, GAP_TICKS=1, PEND_W=2).
module tb_led_flash_out;

    localparam int P    = 10;
    localparam int NON  = 2;
    localparam int NGAP = 1;
    localparam int PMAX = 3;

    logic clock;
    logic reset;

    led_flash_out_if #(.PEND_W(2)) bus ();

    led_flash_out #(
        .TICK_MAX (20'd9),
        .ON_TICKS (8'd2),
        .GAP_TICKS(8'd1),
        .PEND_W   (2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- timeline model ----------------
    // Cycle index c counts clocks since reset release; ticks fall on c%P == P-1.
    // mode: 0 dark/idle, 1 lit, 2 forced-off gap. m_end = first cycle of the next phase.
    int cyc;
    int m_mode;
    int m_q;
    int m_lost;
    int m_end;

    function automatic int phase_end(input int s, input int n);
        int first;
        first = s + (P - 1 - (s % P));
        return first + (n - 1) * P + 1;
    endfunction

    always @(posedge clock or posedge reset) begin
        int mode, q, lost, e, nxt, inc, dec;
        if (reset) begin
            m_mode <= 0; m_q <= 0; m_lost <= 0; m_end <= 0; cyc <= 0;
        end else begin
            mode = m_mode; q = m_q; lost = m_lost; e = m_end;
            nxt = cyc + 1;
            if (bus.clear) begin
                mode = 0; q = 0; lost = 0;
            end else begin
                inc = (bus.evt_in && mode != 0) ? 1 : 0;
                dec = 0;
                case (mode)
                    0: if (bus.evt_in) begin mode = 1; e = phase_end(nxt, NON); end
                    1: if (nxt == e) begin mode = 2; e = phase_end(nxt, NGAP); end
                    2: if (nxt == e) begin
                           if (q > 0) begin dec = 1; mode = 1; e = phase_end(nxt, NON); end
                           else mode = 0;
                       end
                    default: mode = 0;
                endcase
                q = q + inc - dec;
                if (q > PMAX) begin q = PMAX; lost = 1; end
            end
            m_mode <= mode; m_q <= q; m_lost <= lost; m_end <= e; cyc <= nxt;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clock) begin
        if (!reset) begin
            check("led_out",  int'(bus.led_out),  (m_mode == 1) ? 1 : 0);
            check("busy",     int'(bus.busy),     (m_mode != 0) ? 1 : 0);
            check("pending",  int'(bus.pending),  m_q);
            check("overflow", int'(bus.overflow), m_lost);
        end
    end

    // Count LED rising edges seen on the DUT pin.
    int flash_cnt = 0;
    logic prev_led = 1'b0;
    always @(negedge clock) begin
        if (bus.led_out && !prev_led) flash_cnt++;
        prev_led = bus.led_out;
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic tick_to(input int c);
        while (cyc < c) @(negedge clock);
    endtask

    task automatic pulse();
        bus.evt_in = 1'b1;
        @(negedge clock);
        bus.evt_in = 1'b0;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            wait_cyc(1);
            pulse();
        end
    endtask

    int base;
    bit found;

    initial begin
        bus.evt_in = 1'b0;
        bus.clear  = 1'b0;
        reset      = 1'b1;
        wait_cyc(3);
        check("reset_led",  int'(bus.led_out), 0);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_pend", int'(bus.pending), 0);
        reset = 1'b0;

        // 1: single flash; ON cycles 3..19, GAP 20..29, idle at 30.
        base = flash_cnt;
        tick_to(2);
        check("s1_led_c2", int'(bus.led_out), 0);
        pulse();
        check("s1_led_c3", int'(bus.led_out), 1);
        tick_to(19);
        check("s1_led_c19", int'(bus.led_out), 1);
        tick_to(20);
        check("s1_led_c20", int'(bus.led_out), 0);
        check("s1_busy_c20", int'(bus.busy), 1);
        tick_to(29);
        check("s1_busy_c29", int'(bus.busy), 1);
        tick_to(30);
        check("s1_busy_c30", int'(bus.busy), 0);
        check("s1_pending", int'(bus.pending), 0);
        check("s1_flashes", flash_cnt - base, 1);

        // 2: three queued events -> four flashes, no overflow.
        base = flash_cnt;
        pulse();
        pulses(3);
        check("s2_pending3", int'(bus.pending), 3);
        check("s2_no_ovf", int'(bus.overflow), 0);
        wait_cyc(150);
        check("s2_flashes", flash_cnt - base, 4);
        check("s2_idle", int'(bus.busy), 0);
        check("s2_pending0", int'(bus.pending), 0);

        // 3: five queued events -> saturate at 3, overflow sticky.
        base = flash_cnt;
        pulse();
        pulses(5);
        check("s3_pending_sat", int'(bus.pending), 3);
        check("s3_ovf", int'(bus.overflow), 1);
        wait_cyc(150);
        check("s3_flashes", flash_cnt - base, 4);
        check("s3_idle", int'(bus.busy), 0);
        check("s3_ovf_sticky", int'(bus.overflow), 1);
        bus.clear = 1'b1;
        @(negedge clock);
        bus.clear = 1'b0;
        check("s3_ovf_cleared", int'(bus.overflow), 0);

        // 4: event on the GAP->ON edge with pending=1 leaves pending at 1.
        base = flash_cnt;
        pulse();
        pulses(1);
        check("s4_pending1", int'(bus.pending), 1);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (m_mode == 2 && m_end == cyc + 1) found = 1'b1;
            else @(negedge clock);
        end
        check("s4_gap_end_found", int'(found), 1);
        pulse();
        check("s4_pending_held", int'(bus.pending), 1);
        check("s4_led_on", int'(bus.led_out), 1);
        wait_cyc(150);
        check("s4_flashes", flash_cnt - base, 3);

        // 5: clear with pending=2 and a coincident event.
        base = flash_cnt;
        pulse();
        pulses(2);
        check("s5_pending2", int'(bus.pending), 2);
        check("s5_led_on", int'(bus.led_out), 1);
        bus.clear  = 1'b1;
        bus.evt_in = 1'b1;
        @(negedge clock);
        bus.clear  = 1'b0;
        bus.evt_in = 1'b0;
        check("s5_led", int'(bus.led_out), 0);
        check("s5_busy", int'(bus.busy), 0);
        check("s5_pending", int'(bus.pending), 0);
        check("s5_ovf", int'(bus.overflow), 0);
        wait_cyc(60);
        check("s5_flashes", flash_cnt - base, 1);

        // 6: asynchronous reset mid-flash.
        pulse();
        wait_cyc(4);
        check("s6_led_before", int'(bus.led_out), 1);
        @(posedge clock);
        #2 reset = 1'b1;
        #1 check("s6_led_async", int'(bus.led_out), 0);
        wait_cyc(2);
        reset = 1'b0;
        wait_cyc(3);
        check("s6_idle_busy", int'(bus.busy), 0);
        check("s6_idle_pend", int'(bus.pending), 0);
        base = flash_cnt;
        pulse();
        check("s6_new_flash", int'(bus.led_out), 1);
        wait_cyc(40);
        check("s6_flashes", flash_cnt - base, 1);
        check("s6_done", int'(bus.busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
